// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, instruction field placement and the
// decoded-fields struct used by decode and (later) forwarding logic.
package simplerisc_pkg;

  localparam int OPC_W    = 5;
  localparam int IDX_W    = 8;  // widest register index the decoded struct can carry
  localparam int IBIT_OFS = 6;  // I bit sits at INSN_W-IBIT_OFS
  localparam int RD_OFS   = 7;  // rd msb sits at INSN_W-RD_OFS; rs1 and rs2 follow it

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010, OP_DIV = 5'b00011,
    OP_MOD = 5'b00100, OP_CMP = 5'b00101, OP_AND = 5'b00110, OP_OR  = 5'b00111,
    OP_NOT = 5'b01000, OP_MOV = 5'b01001, OP_LSL = 5'b01010, OP_LSR = 5'b01011,
    OP_ASR = 5'b01100, OP_NOP = 5'b01101, OP_LD  = 5'b01110, OP_ST  = 5'b01111,
    OP_BEQ = 5'b10000, OP_BGT = 5'b10001, OP_B   = 5'b10010, OP_CALL = 5'b10011,
    OP_RET = 5'b10100
  } opcode_e;

  typedef struct packed {
    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic [IDX_W-1:0] rd;
    logic             rs1_en;
    logic             rs2_en;
    logic             wr_en;
    logic             flags_wr;
    logic             flags_rd;
    logic             illegal;
  } decode_t;

  // slot 0 = rd, 1 = rs1, 2 = rs2
  function automatic int field_msb(input int insn_w, input int reg_aw, input int slot);
    return insn_w - RD_OFS - slot * reg_aw;
  endfunction

endpackage

// File: rtl/insn_field_decode.sv
// Purely combinational SimpleRISC opcode decoder: register indices and
// read/write enables; unused indices are driven to 0.
module insn_field_decode
  import simplerisc_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int REG_AW = 4,
  parameter int RA_REG = 15
) (
  input  logic [INSN_W-1:0] insn,
  output decode_t           dec
);

  localparam logic [REG_AW-1:0] RA_IDX = REG_AW'(RA_REG);

  logic [OPC_W-1:0]  opc;
  logic              imm;
  logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
  logic              unused_insn;

  assign opc         = insn[INSN_W-1 -: OPC_W];
  assign imm         = insn[INSN_W-IBIT_OFS];
  assign rd_f        = insn[field_msb(INSN_W, REG_AW, 0) -: REG_AW];
  assign rs1_f       = insn[field_msb(INSN_W, REG_AW, 1) -: REG_AW];
  assign rs2_f       = insn[field_msb(INSN_W, REG_AW, 2) -: REG_AW];
  assign unused_insn = ^insn;

  function automatic logic [IDX_W-1:0] ext(input logic [REG_AW-1:0] v);
    return IDX_W'(v);
  endfunction

  always_comb begin
    // NOTE: the all-zero default keeps every struct field assigned on every
    // path, so no latch is inferred and unused indices read as 0.
    dec = '0;
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
        dec.rs1_en = 1'b1;
        dec.rs1    = ext(rs1_f);
        dec.rs2_en = !imm;
        dec.rs2    = imm ? '0 : ext(rs2_f);
        dec.wr_en  = 1'b1;
        dec.rd     = ext(rd_f);
      end
      OP_CMP: begin
        dec.rs1_en   = 1'b1;
        dec.rs1      = ext(rs1_f);
        dec.rs2_en   = !imm;
        dec.rs2      = imm ? '0 : ext(rs2_f);
        dec.flags_wr = 1'b1;
      end
      OP_NOT, OP_MOV: begin
        dec.rs2_en = !imm;
        dec.rs2    = imm ? '0 : ext(rs2_f);
        dec.wr_en  = 1'b1;
        dec.rd     = ext(rd_f);
      end
      OP_LD: begin
        dec.rs1_en = 1'b1;
        dec.rs1    = ext(rs1_f);
        dec.wr_en  = 1'b1;
        dec.rd     = ext(rd_f);
      end
      OP_ST: begin  // the stored register lives in the rd field
        dec.rs1_en = 1'b1;
        dec.rs1    = ext(rs1_f);
        dec.rs2_en = 1'b1;
        dec.rs2    = ext(rd_f);
      end
      OP_BEQ, OP_BGT: dec.flags_rd = 1'b1;
      OP_CALL: begin
        dec.wr_en = 1'b1;
        dec.rd    = ext(RA_IDX);
      end
      OP_RET: begin
        dec.rs1_en = 1'b1;
        dec.rs1    = ext(RA_IDX);
      end
      OP_B, OP_NOP: ;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// SimpleRISC decode/issue stage with a shift-register RAW scoreboard.
// Optional DECODE_HAZARD_STATS_EN adds a saturating stall-cycle counter.
module decode_hazard_stage
  import simplerisc_pkg::*;
#(
  parameter int INSN_W    = 32,
  parameter int REG_AW    = 4,
  parameter int HAZ_DEPTH = 3,
  parameter int RA_REG    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rs1_en,
  output logic              out_rs2_en,
  output logic              out_wr_en,
  output logic              out_flags_wr,
  output logic              out_flags_rd,
  output logic              out_illegal,
  output logic              hazard
`ifdef DECODE_HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              flags_wr;
  } sb_entry_t;

  decode_t           dec;
  logic [REG_AW-1:0] s1, s2;
  logic              unused_dec;
  sb_entry_t         sb    [HAZ_DEPTH];
  sb_entry_t         track [HAZ_DEPTH+1];  // [0] = output register, [1..] = scoreboard
  logic              raw;

  insn_field_decode #(
    .INSN_W(INSN_W),
    .REG_AW(REG_AW),
    .RA_REG(RA_REG)
  ) u_decode (
    .insn(in_insn),
    .dec (dec)
  );

  assign s1         = dec.rs1[REG_AW-1:0];
  assign s2         = dec.rs2[REG_AW-1:0];
  assign unused_dec = ^dec;

  always_comb begin
    track[0].valid    = out_valid & out_wr_en;
    track[0].dest     = out_rd;
    track[0].flags_wr = out_valid & out_flags_wr;
    for (int i = 0; i < HAZ_DEPTH; i++) track[i+1] = sb[i];
  end

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i <= HAZ_DEPTH; i++) begin
      raw |= (track[i].valid && ((dec.rs1_en && s1 == track[i].dest) ||
                                 (dec.rs2_en && s2 == track[i].dest)))
          || (dec.flags_rd && track[i].flags_wr);
    end
  end

  assign hazard   = in_valid & raw;
  assign in_ready = in_valid & ~raw & ~flush & (~out_valid | out_ready);

  // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset so
  // that no stale destination can raise a hazard after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '{default: '0};
    end else if (out_ready) begin
      sb[0] <= (out_valid && !flush) ? track[0] : '0;
      for (int i = 1; i < HAZ_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  // NOTE: non-blocking assignments here let every register sample the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_insn     <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_rs1_en   <= 1'b0;
      out_rs2_en   <= 1'b0;
      out_wr_en    <= 1'b0;
      out_flags_wr <= 1'b0;
      out_flags_rd <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (in_ready) begin
      out_valid    <= 1'b1;
      out_insn     <= in_insn;
      out_rs1      <= s1;
      out_rs2      <= s2;
      out_rd       <= dec.rd[REG_AW-1:0];
      out_rs1_en   <= dec.rs1_en;
      out_rs2_en   <= dec.rs2_en;
      out_wr_en    <= dec.wr_en;
      out_flags_wr <= dec.flags_wr;
      out_flags_rd <= dec.flags_rd;
      out_illegal  <= dec.illegal;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (hazard && ~&stall_cnt)   stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed self-checking bench for decode_hazard_stage (default parameters).
module tb_decode_hazard_stage;

  localparam logic [31:0] ADD_R3   = 32'h00C48000;  // add r3,r1,r2
  localparam logic [31:0] SUB_IND  = 32'h09154000;  // sub r4,r5,r5
  localparam logic [31:0] SUB_DEP  = 32'h090D4000;  // sub r4,r3,r5
  localparam logic [31:0] CMP_R1R2 = 32'h28048000;  // cmp r1,r2
  localparam logic [31:0] BEQ      = 32'h80000000;
  localparam logic [31:0] MOV_R5I  = 32'h4D400000;  // mov r5,#imm

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, hazard;
  logic [31:0] in_insn, out_insn;
  logic [3:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_en, out_rs2_en, out_wr_en, out_flags_wr, out_flags_rd, out_illegal;
`ifdef DECODE_HAZARD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  decode_hazard_stage #(
    .INSN_W(32), .REG_AW(4), .HAZ_DEPTH(3), .RA_REG(15)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_wr_en(out_wr_en),
    .out_flags_wr(out_flags_wr), .out_flags_rd(out_flags_rd), .out_illegal(out_illegal),
    .hazard(hazard)
`ifdef DECODE_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  function automatic logic [17:0] fields();
    return {out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_wr_en,
            out_flags_wr, out_flags_rd, out_illegal};
  endfunction

  // Issue producer p, then offer consumer c; out_ready is low for the first
  // `hold` consumer cycles. Counts hazard cycles until c is accepted.
  task automatic run_pair(input string tag, input logic [31:0] p, input logic [31:0] c,
                          input int hold, input int exp_haz);
    int haz, waited;
    bit done;
    in_insn = p; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    check({tag, "_p_acc"}, in_ready, 1);
    tick();
    check({tag, "_p_valid"}, out_valid, 1);
    check({tag, "_p_insn"}, out_insn, p);
    in_insn = c;
    haz = 0; waited = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      out_ready = (cyc < hold) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (hazard) haz++;
      if (hold > 0 && cyc == hold - 1) begin
        check({tag, "_hold_insn"}, out_insn, p);
        check({tag, "_hold_valid"}, out_valid, 1);
      end
      if (in_ready) done = 1;
      else begin
        waited++;
        tick();
      end
    end
    check({tag, "_timeout"}, done, 1);
    check({tag, "_haz_cycles"}, haz, exp_haz);
    check({tag, "_wait_cycles"}, waited, exp_haz);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    check({tag, "_c_valid"}, out_valid, 1);
    check({tag, "_c_insn"}, out_insn, c);
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [17:0] exp;
    string       tag;
  } dec_vec_t;

  dec_vec_t vecs[$];

  initial begin
    int haz, waited;
    bit done;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_insn = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_insn", out_insn, 0);
    check("rst_fields", fields(), 0);
    check("rst_hazard", hazard, 0);
    tick();
    rst = 1'b0;
    idle(2);

    // independent pair
    run_pair("indep", ADD_R3, SUB_IND, 0, 0);
    check("indep_rd2", out_rd, 4);
    idle(5);

    // dependent pair: HAZ_DEPTH+1 stall cycles
    run_pair("dep", ADD_R3, SUB_DEP, 0, 4);
    check("dep_fields", fields(), {4'd3, 4'd5, 4'd4, 6'b111000});
    idle(5);

    // flags dependency
    run_pair("flags", CMP_R1R2, BEQ, 0, 4);
    check("flags_fields", fields(), {4'd0, 4'd0, 4'd0, 6'b000010});
    idle(5);

    // downstream back-pressure freezes the scoreboard
    run_pair("hold", ADD_R3, SUB_DEP, 3, 7);
    idle(5);

    // flush squashes mov r5 at out; consumer sees only the older add
    in_insn = ADD_R3; in_valid = 1'b1;
    tick();
    in_insn = MOV_R5I;
    @(negedge clk);
    check("fl_mov_acc", in_ready, 1);
    tick();
    in_insn = SUB_DEP; flush = 1'b1;
    @(negedge clk);
    check("fl_haz_c2", hazard, 1);
    check("fl_no_acc", in_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    haz = 1; waited = 1; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (hazard) haz++;
      if (in_ready) done = 1;
      else begin
        waited++;
        tick();
      end
    end
    check("fl_timeout", done, 1);
    check("fl_haz_cycles", haz, 3);
    check("fl_wait_cycles", waited, 3);
    tick();
    in_valid = 1'b0;
    check("fl_c_insn", out_insn, SUB_DEP);
    idle(5);

    // decode table, each instruction issued from an empty pipeline
    vecs.push_back('{32'h00C48000, {4'd1, 4'd2, 4'd3, 6'b111000}, "dec_add"});
    vecs.push_back('{32'h04C48000, {4'd1, 4'd0, 4'd3, 6'b101000}, "dec_addi"});
    vecs.push_back('{32'h799C0000, {4'd7, 4'd6, 4'd0, 6'b110000}, "dec_st"});
    vecs.push_back('{32'h70A7C000, {4'd9, 4'd0, 4'd2, 6'b101000}, "dec_ld"});
    vecs.push_back('{32'hA0000000, {4'd15, 4'd0, 4'd0, 6'b100000}, "dec_ret"});
    vecs.push_back('{32'h98000000, {4'd0, 4'd0, 4'd15, 6'b001000}, "dec_call"});
    vecs.push_back('{MOV_R5I,      {4'd0, 4'd0, 4'd5, 6'b001000}, "dec_movi"});
    vecs.push_back('{CMP_R1R2,     {4'd1, 4'd2, 4'd0, 6'b110100}, "dec_cmp"});
    vecs.push_back('{32'hF8000000, {4'd0, 4'd0, 4'd0, 6'b000001}, "dec_illegal"});
    foreach (vecs[k]) begin
      in_insn = vecs[k].insn; in_valid = 1'b1;
      @(negedge clk);
      check({vecs[k].tag, "_nostall"}, {hazard, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check({vecs[k].tag, "_valid"}, out_valid, 1);
      check({vecs[k].tag, "_fields"}, fields(), vecs[k].exp);
      idle(5);
    end

    // reset in the middle of a stall
    in_insn = ADD_R3; in_valid = 1'b1;
    tick();
    in_insn = SUB_DEP;
    @(negedge clk);
    check("rs_haz_before", hazard, 1);
    rst = 1'b1;
    tick();
    check("rs_out_valid", out_valid, 0);
    check("rs_hazard", hazard, 0);
    check("rs_out_insn", out_insn, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
